// File: rtl/mem_stage_ctrl_pkg.sv
// Purpose: shared types and helpers for the MEM-stage data-memory controller.
//   mem_fsm_t       : controller state encoding
//   load/store enums: RV32I funct3 encodings for loads and stores
//   dmem_req_t      : registered data-memory request payload
//   store_mask/store_data/is_misaligned : store lane steering and alignment check
package mem_stage_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned MASK_W = XLEN / 8;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_fsm_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [MASK_W-1:0] wmask;
    logic [XLEN-1:0]   wdata;
  } dmem_req_t;

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [MASK_W-1:0] store_mask(input logic [2:0] funct3,
                                                   input logic [1:0] offset);
    case (funct3)
      SB:      store_mask = 4'b0001 << offset;
      SH:      store_mask = 4'b0011 << offset;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  // Replicate the store value so every candidate lane carries it; the mask picks.
  function automatic logic [XLEN-1:0] store_data(input logic [2:0] funct3,
                                                 input logic [XLEN-1:0] wdata);
    case (funct3)
      SB:      store_data = {4{wdata[7:0]}};
      SH:      store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  // Load and store size encodings coincide, so one check covers both.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] offset);
    case (funct3)
      LB, LBU:  is_misaligned = 1'b0;
      LH, LHU:  is_misaligned = offset[0];
      default:  is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_load_align.sv
// Purpose: combinational load extraction; selects the byte/half lane at the
//   latched offset and sign- or zero-extends it.
// Ports:
//   rdata_i  : raw 32-bit word from data memory
//   funct3_i : load funct3 of the op in flight
//   offset_i : byte offset (addr[1:0]) of the op in flight
//   data_o   : extended load value
module mem_stage_ctrl_load_align
  import mem_stage_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = rdata_i[7:0];
    case (offset_i)
      2'd0: byte_c = rdata_i[7:0];
      2'd1: byte_c = rdata_i[15:8];
      2'd2: byte_c = rdata_i[23:16];
      2'd3: byte_c = rdata_i[31:24];
      default: byte_c = rdata_i[7:0];
    endcase
    half_c = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      LB:      data_o = {{(XLEN-8){byte_c[7]}}, byte_c};
      LBU:     data_o = {{(XLEN-8){1'b0}}, byte_c};
      LH:      data_o = {{(XLEN-16){half_c[15]}}, half_c};
      LHU:     data_o = {{(XLEN-16){1'b0}}, half_c};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Purpose: MEM-stage controller; turns one load/store into a single held
//   data-memory transaction, stalls the pipeline until it completes and
//   returns the extended load value to WB.
// Ports:
//   clk, rst                     : clock, async active-high reset
//   mem_valid/mem_rd/mem_wr      : EX/MEM op valid and its read/write control
//   funct3, mem_addr, mem_wdata  : access size/sign, byte address, store value
//   dmem_address/read/write/wmask/wdata : registered data-memory request
//   dmem_rdata, dmem_resp        : data-memory read data and completion pulse
//   stall                        : combinational pipeline freeze
//   load_data, done              : load result and completion pulse
//   misaligned                   : pulse when an op is dropped for alignment
//   perf_stall_cnt               : saturating count of stall cycles
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN-1:0]   dmem_address,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [MASK_W-1:0] dmem_wmask,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_resp,
  output logic              stall,
  output logic [XLEN-1:0]   load_data,
  output logic              done,
  output logic              misaligned,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  mem_fsm_t        state_q, state_d;
  dmem_req_t       req_q, req_d;
  logic            rd_q, rd_d, wr_q, wr_d;
  logic            done_q, done_d, mis_q, mis_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [XLEN-1:0] load_q, load_d, load_ext;
  logic [PERF_W-1:0] cnt_q;

  logic op_req, op_mis, accept;

  assign op_req = mem_valid & (mem_rd | mem_wr);
  assign op_mis = is_misaligned(funct3, mem_addr[1:0]);
  assign accept = (state_q == MEM_IDLE) & op_req & ~op_mis;
  assign stall  = accept | (state_q == MEM_REQ);

  mem_stage_ctrl_load_align u_load_align (
    .rdata_i  (dmem_rdata),
    .funct3_i (f3_q),
    .offset_i (off_q),
    .data_o   (load_ext)
  );

  // Next-state and request capture; mem_rd wins when both rd and wr are set.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    off_d   = off_q;
    load_d  = load_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (op_req && op_mis) begin
          mis_d = 1'b1;
        end else if (accept) begin
          state_d     = MEM_REQ;
          rd_d        = mem_rd;
          wr_d        = ~mem_rd;
          req_d.addr  = {mem_addr[XLEN-1:2], 2'b00};
          req_d.wmask = mem_rd ? '0 : store_mask(funct3, mem_addr[1:0]);
          req_d.wdata = mem_rd ? '0 : store_data(funct3, mem_wdata);
          f3_d        = funct3;
          off_d       = mem_addr[1:0];
        end
      end
      MEM_REQ: begin
        if (dmem_resp) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = 1'b1;
          state_d = MEM_DONE;
          if (rd_q) load_d = load_ext;
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  // Reset drops the request immediately and abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      req_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      load_q  <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      load_q  <= load_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != {PERF_W{1'b1}})) begin
      cnt_q <= cnt_q + PERF_W'(1);
    end
  end

  assign dmem_address   = req_q.addr;
  assign dmem_wmask     = req_q.wmask;
  assign dmem_wdata     = req_q.wdata;
  assign dmem_read      = rd_q;
  assign dmem_write     = wr_q;
  assign load_data      = load_q;
  assign done           = done_q;
  assign misaligned     = mis_q;
  assign perf_stall_cnt = cnt_q;

endmodule
